pc_fetch_unit: RTL and testbench

Instruction-fetch and PC sequencing block for the non-pipelined MIPS core. It consumes the control unit's per-instruction strobes (`pcupdate`, `branch`, `jump`) and the ALU `zero` flag. It fetches instruction words over a ready-based request interface, holds the current instruction stable, and returns the opcode to the control unit. On each `pcupdate` it computes the next PC (sequential, branch or jump), and it stops fetching on the halt opcode.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/pc_fetch_unit_if.sv | 13 +
 rtl/pc_fetch_unit_next_pc_calc.sv | 31 +++
 rtl/pc_fetch_unit.sv | 114 +++++++++++
 tb/tb_pc_fetch_unit.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: word width, opcodes, fetch FSM state encoding.
package mips_pkg;

   localparam int unsigned WORD_W = 32;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } fetch_state_e;

   // Sign-extend a 16-bit immediate to a full word.
   function automatic logic [WORD_W-1:0] sext16(input logic [15:0] imm);
      return {{(WORD_W-16){imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request bus: ready-based, data returned in the accepting cycle.
interface pc_fetch_unit_if;
   import mips_pkg::*;

   logic              req;
   logic [WORD_W-1:0] addr;
   logic              ready;
   logic [WORD_W-1:0] rdata;

   modport master (output req, output addr, input ready, input rdata);
   modport slave  (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Next-PC selection: jump beats taken branch beats sequential. All math is modulo 2^32.
module next_pc_calc
   import mips_pkg::*;
(
   input  logic [WORD_W-1:0] pc_i,
   input  logic [25:0]       instr_idx_i,
   input  logic              branch_i,
   input  logic              jump_i,
   input  logic              zero_i,
   output logic [WORD_W-1:0] pc_plus4_o,
   output logic [WORD_W-1:0] next_pc_o
);

   logic [WORD_W-1:0] br_target;
   logic [WORD_W-1:0] jmp_target;

   // Compute candidate targets and pick by priority.
   always_comb begin
      pc_plus4_o = pc_i + 32'd4;
      br_target  = pc_plus4_o + (sext16(instr_idx_i[15:0]) << 2);
      jmp_target = {pc_plus4_o[31:28], instr_idx_i, 2'b00};
      if (jump_i) begin
         next_pc_o = jmp_target;
      end else if (branch_i && zero_i) begin
         next_pc_o = br_target;
      end else begin
         next_pc_o = pc_plus4_o;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch and PC sequencing for the non-pipelined MIPS core.
module pc_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC    = 32'h0000_0000,
   parameter logic [5:0]        HALT_OPCODE = 6'b111111
)
(
   input  logic                 clk,
   input  logic                 reset,
   pc_fetch_unit_if.master      imem,
   input  logic                 pcupdate,
   input  logic                 branch,
   input  logic                 jump,
   input  logic                 zero,
   output logic [WORD_W-1:0]    pc,
   output logic [WORD_W-1:0]    pc_plus4,
   output logic [WORD_W-1:0]    instr,
   output logic [5:0]           opcode,
   output logic                 instr_valid,
   output logic                 halted,
   output logic                 proto_err
);

   localparam logic [WORD_W-1:0] RESET_PC_ALIGNED = {RESET_PC[WORD_W-1:2], 2'b00};

   fetch_state_e      state_q, state_d;
   logic [WORD_W-1:0] pc_q, pc_d;
   logic [WORD_W-1:0] instr_q, instr_d;
   logic              instr_valid_q, instr_valid_d;
   logic              halted_q, halted_d;
   logic              proto_err_q, proto_err_d;
   logic [WORD_W-1:0] next_pc;

   next_pc_calc u_next_pc (
      .pc_i        (pc_q),
      .instr_idx_i (instr_q[25:0]),
      .branch_i    (branch),
      .jump_i      (jump),
      .zero_i      (zero),
      .pc_plus4_o  (pc_plus4),
      .next_pc_o   (next_pc)
   );

   assign imem.req    = (state_q == ST_FETCH);
   assign imem.addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[31:26];
   assign instr_valid = instr_valid_q;
   assign halted      = halted_q;
   assign proto_err   = proto_err_q;

   // State and datapath registers; reset aborts any pending fetch at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_FETCH;
         pc_q          <= RESET_PC_ALIGNED;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
         proto_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         halted_q      <= halted_d;
         proto_err_q   <= proto_err_d;
      end
   end

   // Next-state logic: fetch on ready, retire on pcupdate, park in HALT.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      halted_d      = halted_q;
      proto_err_d   = proto_err_q;
      unique case (state_q)
         ST_FETCH: begin
            if (pcupdate) begin
               proto_err_d = 1'b1;
            end
            if (imem.ready) begin
               instr_d       = imem.rdata;
               instr_valid_d = 1'b1;
               if (imem.rdata[31:26] == HALT_OPCODE) begin
                  state_d  = ST_HALT;
                  halted_d = 1'b1;
               end else begin
                  state_d = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            if (pcupdate) begin
               pc_d          = next_pc;
               instr_valid_d = 1'b0;
               state_d       = ST_FETCH;
            end
         end
         ST_HALT: begin
            halted_d      = 1'b1;
            instr_valid_d = 1'b1;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: fetch transactions go through a scoreboard queue.
module tb_pc_fetch_unit;

   typedef struct packed {
      logic [31:0] addr;
      logic [5:0]  op;
      logic        halt;
   } fetch_exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        pcupdate = 1'b0;
   logic        branch = 1'b0;
   logic        jump = 1'b0;
   logic        zero = 1'b0;
   logic [31:0] pc, pc_plus4, instr;
   logic [5:0]  opcode;
   logic        instr_valid, halted, proto_err;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   fetch_exp_t  exp_q[$];

   pc_fetch_unit_if imem_bus ();
   assign imem_bus.ready = imem_ready;
   assign imem_bus.rdata = imem_rdata;
   assign imem_req       = imem_bus.req;
   assign imem_addr      = imem_bus.addr;

   pc_fetch_unit #(
      .RESET_PC    (32'h0000_0003),
      .HALT_OPCODE (6'h3F)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem        (imem_bus),
      .pcupdate    (pcupdate),
      .branch      (branch),
      .jump        (jump),
      .zero        (zero),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .instr       (instr),
      .opcode      (opcode),
      .instr_valid (instr_valid),
      .halted      (halted),
      .proto_err   (proto_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one fetch, optionally stalling ready for some cycles first.
   task automatic do_fetch(input logic [31:0] word, input logic [31:0] exp_addr,
                           input int unsigned waits);
      fetch_exp_t e;
      e.addr = exp_addr;
      e.op   = word[31:26];
      e.halt = (word[31:26] == 6'h3F);
      exp_q.push_back(e);
      imem_ready = 1'b0;
      for (int unsigned i = 0; i < waits; i++) begin
         check("stall_addr", imem_addr, exp_addr);
         check("stall_req", {31'b0, imem_req}, 32'd1);
         step();
      end
      imem_rdata = word;
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
   endtask

   task automatic retire(input string name, input logic br, input logic jp, input logic z,
                         input logic [31:0] exp_pc);
      pcupdate = 1'b1;
      branch   = br;
      jump     = jp;
      zero     = z;
      step();
      pcupdate = 1'b0;
      branch   = 1'b0;
      jump     = 1'b0;
      zero     = 1'b0;
      check(name, pc, exp_pc);
      check({name, "_req"}, {31'b0, imem_req}, 32'd1);
      check({name, "_valid"}, {31'b0, instr_valid}, 32'd0);
   endtask

   // Monitor: every accepted fetch is matched against the next expected entry.
   initial begin
      fetch_exp_t e;
      forever begin
         @(negedge clk);
         if (imem_req && imem_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_fetch_addr", imem_addr, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("fetch_addr", imem_addr, e.addr);
               @(posedge clk);
               #1;
               check("fetch_opcode", {26'b0, opcode}, {26'b0, e.op});
               check("fetch_valid", {31'b0, instr_valid}, 32'd1);
               check("fetch_halted", {31'b0, halted}, {31'b0, e.halt});
            end
         end
      end
   end

   initial begin
      // Reset with a misaligned RESET_PC: low bits must be cleared.
      #1 reset = 1'b1;
      #1;
      check("rst_pc", pc, 32'h0);
      check("rst_req", {31'b0, imem_req}, 32'd1);
      check("rst_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_halted", {31'b0, halted}, 32'd0);
      check("rst_proto", {31'b0, proto_err}, 32'd0);
      check("rst_instr", instr, 32'h0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      step();

      // Stalled fetch, then sequential retire.
      do_fetch(32'h2008_0005, 32'h0, 3);
      retire("seq_pc", 1'b0, 1'b0, 1'b0, 32'h4);

      // Jump from 0x4 to 0x10.
      do_fetch(32'h0800_0004, 32'h4, 0);
      retire("jmp_pc", 1'b0, 1'b1, 1'b0, 32'h10);

      // BEQ offset -1: taken loops to itself, not-taken falls through.
      do_fetch(32'h1000_FFFF, 32'h10, 0);
      retire("beq_taken_pc", 1'b1, 1'b0, 1'b1, 32'h10);
      do_fetch(32'h1000_FFFF, 32'h10, 1);
      retire("beq_nt_pc", 1'b1, 1'b0, 1'b0, 32'h14);

      // Most-negative branch below address 0 wraps; strobes without pcupdate do nothing.
      do_fetch(32'h1000_8000, 32'h14, 0);
      branch = 1'b1;
      jump   = 1'b1;
      zero   = 1'b1;
      step();
      check("no_strobe_pc", pc, 32'h14);
      check("no_strobe_valid", {31'b0, instr_valid}, 32'd1);
      check("no_strobe_req", {31'b0, imem_req}, 32'd0);
      retire("beq_wrap_pc", 1'b1, 1'b0, 1'b1, 32'hFFFE_0018);

      // Jump with branch also asserted: jump wins, lands on the top word.
      do_fetch(32'h0BFF_FFFF, 32'hFFFE_0018, 0);
      retire("jmp_wins_pc", 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);

      // Sequential retire at the top of memory wraps to 0.
      do_fetch(32'h2008_0001, 32'hFFFF_FFFC, 0);
      check("pc_plus4_wrap", pc_plus4, 32'h0);
      retire("seq_wrap_pc", 1'b0, 1'b0, 1'b0, 32'h0);

      // Walk to 0x8 and reset asynchronously in EXEC.
      do_fetch(32'h2008_0002, 32'h0, 0);
      retire("walk0_pc", 1'b0, 1'b0, 1'b0, 32'h4);
      do_fetch(32'h2008_0003, 32'h4, 0);
      retire("walk1_pc", 1'b0, 1'b0, 1'b0, 32'h8);
      do_fetch(32'h1000_0001, 32'h8, 0);
      #2 reset = 1'b1;
      #1;
      check("async_rst_pc", pc, 32'h0);
      check("async_rst_valid", {31'b0, instr_valid}, 32'd0);
      check("async_rst_instr", instr, 32'h0);
      check("async_rst_req", {31'b0, imem_req}, 32'd1);
      #3 reset = 1'b0;
      step();

      // Halt word: fetch stops, pcupdate ignored, no protocol error.
      do_fetch(32'hFC00_0000, 32'h0, 1);
      for (int unsigned i = 0; i < 10; i++) begin
         pcupdate   = i[0];
         imem_ready = 1'b1;
         step();
         check("halt_req", {31'b0, imem_req}, 32'd0);
         check("halt_flag", {31'b0, halted}, 32'd1);
         check("halt_pc", pc, 32'h0);
         check("halt_valid", {31'b0, instr_valid}, 32'd1);
         check("halt_proto", {31'b0, proto_err}, 32'd0);
      end
      pcupdate   = 1'b0;
      imem_ready = 1'b0;

      // Fresh reset, then pcupdate while fetching flags a protocol error.
      #2 reset = 1'b1;
      #1;
      check("rst2_halted", {31'b0, halted}, 32'd0);
      #3 reset = 1'b0;
      step();
      pcupdate = 1'b1;
      step();
      pcupdate = 1'b0;
      check("proto_set", {31'b0, proto_err}, 32'd1);
      check("proto_pc", pc, 32'h0);
      check("proto_req", {31'b0, imem_req}, 32'd1);
      do_fetch(32'h2008_0009, 32'h0, 0);
      check("proto_sticky", {31'b0, proto_err}, 32'd1);

      repeat (3) step();
      check("scoreboard_drain", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
